// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit and HI/LO register file.
// MULT/MULTU/MT* write HI/LO in one cycle; DIV/DIVU use a 32-step restoring divider.
module ex_mdu #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush_i,
    input  logic              stall_ex_i,
    input  logic [2:0]        mdu_op_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CW = $clog2(DATA_W);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] dvd_q, dvs_q, rem_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic              quo_neg_q, rem_neg_q;

    logic              is_mul, is_div, div_signed;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_abs, b_abs;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod;
    logic [DATA_W:0]   r_sh, diff;
    logic              fits;
    logic [DATA_W-1:0] r_next, q_next, quo_fix, rem_fix;
    logic              stall, start, finish, in_idle;

    assign is_mul     = (mdu_op_i == OP_MULT) || (mdu_op_i == OP_MULTU);
    assign is_div     = (mdu_op_i == OP_DIV) || (mdu_op_i == OP_DIVU);
    assign div_signed = (mdu_op_i == OP_DIV);
    assign a_neg      = div_signed & src_a_i[DATA_W-1];
    assign b_neg      = div_signed & src_b_i[DATA_W-1];
    assign a_abs      = a_neg ? -src_a_i : src_a_i;
    assign b_abs      = b_neg ? -src_b_i : src_b_i;

    // Sign- or zero-extend to 2W so one multiplier serves MULT and MULTU
    always_comb begin
        ext_a = {{DATA_W{1'b0}}, src_a_i};
        ext_b = {{DATA_W{1'b0}}, src_b_i};
        if (mdu_op_i == OP_MULT) begin
            ext_a = {{DATA_W{src_a_i[DATA_W-1]}}, src_a_i};
            ext_b = {{DATA_W{src_b_i[DATA_W-1]}}, src_b_i};
        end
        prod = ext_a * ext_b;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign r_sh    = {rem_q, dvd_q[DATA_W-1]};
    assign diff    = r_sh - {1'b0, dvs_q};
    assign fits    = ~diff[DATA_W];
    assign r_next  = fits ? diff[DATA_W-1:0] : r_sh[DATA_W-1:0];
    assign q_next  = {dvd_q[DATA_W-2:0], fits};
    assign quo_fix = quo_neg_q ? -q_next : q_next;
    assign rem_fix = rem_neg_q ? -r_next : r_next;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        start   = 1'b0;
        finish  = 1'b0;
        in_idle = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_idle = 1'b1;
                    if (is_div) begin
                        stall   = 1'b1;
                        start   = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    stall = 1'b1;
                    if (count_q == CW'(DATA_W - 1)) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (!stall_ex_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign stall_o = stall & resetn;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                count_q <= '0;
            end else if (start) begin
                count_q   <= '0;
                dvd_q     <= a_abs;
                dvs_q     <= b_abs;
                rem_q     <= '0;
                quo_neg_q <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
            end else if (state_q == RUN) begin
                count_q <= count_q + CW'(1);
                dvd_q   <= q_next;
                rem_q   <= r_next;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= RST_VAL;
            lo_q <= RST_VAL;
        end else if (finish) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
        end else if (in_idle) begin
            if (is_mul) begin
                hi_q <= prod[2*DATA_W-1:DATA_W];
                lo_q <= prod[DATA_W-1:0];
            end
            if (mdu_op_i == OP_MTHI) hi_q <= src_a_i;
            if (mdu_op_i == OP_MTLO) lo_q <= src_a_i;
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: randomized self-checking bench for ex_mdu
// against an arithmetic reference model of HI/LO and stall timing.
module tb_ex_mdu;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSV   = 3'd7;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        flush_i = 1'b0;
    logic        stall_ex_i = 1'b0;
    logic [2:0]  mdu_op_i = OP_NOP;
    logic [31:0] src_a_i = '0;
    logic [31:0] src_b_i = '0;
    logic        stall_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int failures = 0;

    ex_mdu dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush_i   (flush_i),
        .stall_ex_i(stall_ex_i),
        .mdu_op_i  (mdu_op_i),
        .src_a_i   (src_a_i),
        .src_b_i   (src_b_i),
        .stall_o   (stall_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Returns {HI, LO}
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] lo, hi;
        if (b == 32'd0) begin
            lo = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            hi = a;
        end else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
        return {hi, lo};
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdu_op_i = op;
        src_a_i  = a;
        src_b_i  = b;
    endtask

    // Issues a divide and counts stall cycles; returns in the first non-stall cycle.
    task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int stalls);
        @(negedge clk);
        mdu_op_i = op;
        src_a_i  = a;
        src_b_i  = b;
        #1;
        stalls = 0;
        while (stall_o === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
            src_a_i = $urandom;
            src_b_i = $urandom;
            #1;
        end
    endtask

    task automatic test_reset;
        #2 resetn = 1'b0;
        mdu_op_i = OP_MULT;
        src_a_i  = 32'd3;
        src_b_i  = 32'd5;
        repeat (3) @(negedge clk);
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got %b want 0", stall_o);
        end
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_hilo got %h_%h want 0_0", hi_o, lo_o);
        end
        resetn   = 1'b1;
        mdu_op_i = OP_NOP;
        @(negedge clk);
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_release got %h_%h want 0_0", hi_o, lo_o);
        end
    endtask

    task automatic test_mult;
        do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL mult_stall got %b want 0", stall_o);
        end
        @(negedge clk);
        mdu_op_i = OP_NOP;
        checks++;
        if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFA) begin
            failures++;
            $display("FAIL mult_neg got %h_%h want ffffffff_fffffffa", hi_o, lo_o);
        end
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL multu_stall got %b want 0", stall_o);
        end
        @(negedge clk);
        mdu_op_i = OP_NOP;
        checks++;
        if (hi_o !== 32'hFFFF_FFFE || lo_o !== 32'h0000_0001) begin
            failures++;
            $display("FAIL multu_max got %h_%h want fffffffe_00000001", hi_o, lo_o);
        end
    endtask

    task automatic test_random_mul;
        logic [31:0] exp_hi, exp_lo, a, b;
        logic [63:0] p;
        logic [2:0]  op;
        exp_hi = hi_o;
        exp_lo = lo_o;
        for (int i = 0; i < 20; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom_range(0, 7));
            if (op == OP_DIV || op == OP_DIVU) op = OP_MULT;
            do_op(op, a, b);
            #1;
            checks++;
            if (stall_o !== 1'b0) begin
                failures++;
                $display("FAIL rmul_stall[%0d] op=%0d got %b want 0", i, op, stall_o);
            end
            if (op == OP_MULT || op == OP_MULTU) begin
                p = ref_mul(op == OP_MULT, a, b);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end else if (op == OP_MTHI) begin
                exp_hi = a;
            end else if (op == OP_MTLO) begin
                exp_lo = a;
            end
            @(negedge clk);
            mdu_op_i = OP_NOP;
            checks++;
            if (hi_o !== exp_hi || lo_o !== exp_lo) begin
                failures++;
                $display("FAIL rmul[%0d] op=%0d got %h_%h want %h_%h",
                         i, op, hi_o, lo_o, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_div_example;
        int n;
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
        checks++;
        if (n != 33) begin
            failures++;
            $display("FAIL div_ex_stalls got %0d want 33", n);
        end
        checks++;
        if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_ex got %h_%h want ffffffff_fffffffd", hi_o, lo_o);
        end
        // DIV still in EX: one DONE cycle, then IDLE sees it as a fresh issue
        @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            failures++;
            $display("FAIL div_ex_idle got %b want 1", stall_o);
        end
        flush_i  = 1'b1;
        mdu_op_i = OP_NOP;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL div_ex_flushstall got %b want 0", stall_o);
        end
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    task automatic test_div_bounds;
        int n;
        run_div(OP_DIVU, 32'd100, 32'd0, n);
        checks++;
        if (n != 33 || hi_o !== 32'd100 || lo_o !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL divu_zero stalls=%0d got %h_%h want 33 00000064_ffffffff", n, hi_o, lo_o);
        end
        run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++;
        if (n != 33 || hi_o !== 32'd0 || lo_o !== 32'h8000_0000) begin
            failures++;
            $display("FAIL div_ovf stalls=%0d got %h_%h want 33 00000000_80000000", n, hi_o, lo_o);
        end
        run_div(OP_DIV, 32'hFFFF_FFFB, 32'd0, n);
        checks++;
        if (n != 33 || hi_o !== 32'hFFFF_FFFB || lo_o !== 32'd1) begin
            failures++;
            $display("FAIL div_zero_neg stalls=%0d got %h_%h want 33 fffffffb_00000001", n, hi_o, lo_o);
        end
    endtask

    task automatic test_random_div;
        int n;
        logic [31:0] a, b;
        logic [63:0] e;
        logic sgn;
        for (int i = 0; i < 8; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 2 == 1) b = -b;
            e = ref_div(sgn, a, b);
            run_div(sgn ? OP_DIV : OP_DIVU, a, b, n);
            checks++;
            if (n != 33 || hi_o !== e[63:32] || lo_o !== e[31:0]) begin
                failures++;
                $display("FAIL rdiv[%0d] s=%0d a=%h b=%h stalls=%0d got %h_%h want %h_%h",
                         i, sgn, a, b, n, hi_o, lo_o, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_flush;
        do_op(OP_MTHI, 32'h1234_5678, 32'd0);
        do_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        do_op(OP_DIV, 32'd1000, 32'd3);
        repeat (11) @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_prerun got %b want 1", stall_o);
        end
        flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall got %b want 0", stall_o);
        end
        @(negedge clk);
        flush_i  = 1'b0;
        mdu_op_i = OP_NOP;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle got %b want 0", stall_o);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (hi_o !== 32'h1234_5678 || lo_o !== 32'h9ABC_DEF0) begin
            failures++;
            $display("FAIL flush_hilo got %h_%h want 12345678_9abcdef0", hi_o, lo_o);
        end
        do_op(OP_MTLO, 32'd5, 32'd0);
        @(negedge clk);
        mdu_op_i = OP_NOP;
        checks++;
        if (hi_o !== 32'h1234_5678 || lo_o !== 32'd5) begin
            failures++;
            $display("FAIL flush_mtlo got %h_%h want 12345678_00000005", hi_o, lo_o);
        end
    endtask

    task automatic test_done_hold;
        int n;
        run_div(OP_DIVU, 32'd9, 32'd4, n);
        checks++;
        if (n != 33 || hi_o !== 32'd1 || lo_o !== 32'd2) begin
            failures++;
            $display("FAIL hold_div stalls=%0d got %h_%h want 33 00000001_00000002", n, hi_o, lo_o);
        end
        stall_ex_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (stall_o !== 1'b0 || hi_o !== 32'd1 || lo_o !== 32'd2) begin
                failures++;
                $display("FAIL hold_done[%0d] stall=%b got %h_%h want 0 00000001_00000002",
                         i, stall_o, hi_o, lo_o);
            end
        end
        stall_ex_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            failures++;
            $display("FAIL hold_idle got %b want 1", stall_o);
        end
        flush_i  = 1'b1;
        mdu_op_i = OP_NOP;
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        do_op(OP_MULT, 32'd7, 32'd9);
        do_op(OP_DIV, 32'd12345, 32'd7);
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd63) begin
            failures++;
            $display("FAIL rst_pre got %h_%h want 00000000_0000003f", hi_o, lo_o);
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_run got %b want 1", stall_o);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid stall=%b got %h_%h want 0 0_0", stall_o, hi_o, lo_o);
        end
        @(negedge clk);
        mdu_op_i = OP_NOP;
        resetn   = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            failures++;
            $display("FAIL rst_after stall=%b got %h_%h want 0 0_0", stall_o, hi_o, lo_o);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_random_mul();
        test_div_example();
        test_div_bounds();
        test_random_div();
        test_flush();
        test_done_hold();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
